b_tile_loader: RTL and testbench
================================

B_TILE_LOADER -- requirements
Module: b_tile_loader

Interface
REQ-001: Parameter BITS_AB, default 8, width of one signed B element.
REQ-002: Parameter DIM, default 8, systolic array dimension: elements per row and rows per tile.
REQ-003: clk  input  1  rising-edge clock.
REQ-004: rst_n  input  1  reset, asynchronous, active-low.
REQ-005: wr_valid  input  1  host row-write request.
REQ-006: wr_data  input  DIM*BITS_AB  packed B row; element k at bits [k*BITS_AB +: BITS_AB].
REQ-007: wr_ready  output  1  loader accepts a row this cycle.
REQ-008: start  input  1  request to stream the buffered tile into the B skew buffer.
REQ-009: abort  input  1  synchronous discard of the tile and any stream in progress.
REQ-010: b_en  output  1  shift enable to the B skew buffer.
REQ-011: b_row  output  signed BITS_AB x DIM array  row driven to the skew buffer; element k = b_row[k].
REQ-012: full  output  1  DIM rows buffered; tile ready to stream.
REQ-013: busy  output  1  streaming or flushing in progress.
REQ-014: done  output  1  one-cycle pulse on stream completion.

Function
REQ-015: Storage: DIM x DIM signed BITS_AB registers plus row counter wr_cnt of width $clog2(DIM)+1.
REQ-016: FSM states: FILL, FULL, STREAM, FLUSH; reset state FILL.
REQ-017: wr_ready = (state==FILL); a write occurs when wr_valid && wr_ready.
REQ-018: On a write, the row is stored at index wr_cnt and wr_cnt increments by 1.
REQ-019: The write storing row DIM-1 moves the state FILL->FULL on the next edge; wr_cnt then equals DIM.
REQ-020: In FULL, wr_ready=0; wr_valid is ignored and no buffered row is modified.
REQ-021: FULL->STREAM on start; start in FILL, STREAM or FLUSH is ignored with no effect.
REQ-022: STREAM lasts exactly DIM cycles: in cycle r (r=0..DIM-1), b_en=1 and b_row = stored row r.
REQ-023: STREAM->FLUSH after cycle DIM-1; FLUSH lasts exactly 2*DIM-1 cycles with b_en=1 and b_row all zeros, draining the skew buffer.
REQ-024: The first STREAM cycle is the cycle after start is sampled; total b_en-high run = 3*DIM-1 consecutive cycles (23 at DIM=8).
REQ-025: On the last FLUSH cycle exit, done=1 for one cycle, state goes to FILL, wr_cnt=0, and wr_ready=1 in that same cycle.
REQ-026: b_en=0 and b_row=0 in FILL and FULL; b_en, b_row and done are registered outputs.
REQ-027: full = (state==FULL); busy = (state==STREAM || state==FLUSH).
REQ-028: abort takes priority over start and writes in every state: next state FILL, wr_cnt=0, b_en=0, b_row=0, done not asserted.
REQ-029: Abort mid-STREAM/FLUSH truncates the b_en run with no further enabled cycles; stored row contents may remain but are overwritten by the next fill.
REQ-030: Elements pass bit-exact; no sign extension, saturation or reordering.

Reset
REQ-031: On rst_n low, asynchronously: state=FILL, wr_cnt=0, all buffer rows=0, b_en=0, b_row=0, done=0; therefore full=0, busy=0, wr_ready=1.
REQ-032: Reset asserted mid-stream forces the values of REQ-031 immediately, and no b_en pulse follows deassertion.

Verification
REQ-033: Fill: 8 writes of rows with element k of row r = 8r+k (+1 offset) -> wr_ready low after 8th write, full=1, b_en=0 throughout.
REQ-034: Stream: start in FULL -> next 8 cycles b_row = rows 0..7 in order with b_en=1, then 15 zero-row cycles, done pulse one cycle, wr_ready=1 the same cycle.
REQ-035: Ignored inputs: start during FILL with 3 rows loaded -> no b_en; wr_valid held in FULL -> buffer unchanged, stream output matches original rows.
REQ-036: Abort at STREAM cycle 4 -> b_en low next cycle, state FILL, wr_cnt=0, no done; refill and stream reproduces new tile exactly.
REQ-037: Negative values: row of -128,-1,127,0,... -> identical bit patterns on b_row; end-to-end with skew buffer, skew-buffer output returns to all zeros after flush.
REQ-038: Asynchronous reset pulse during FLUSH -> all outputs at REQ-031 values without a clock edge; first write after release stored at row 0.

Source files
------------

// File: rtl/b_tile_loader.sv
// rtl/b_tile_loader.sv - buffers one DIM x DIM B tile and streams it, then a zero flush, into the B skew buffer
module b_tile_loader #(
  parameter int BITS_AB = 8,
  parameter int DIM     = 8
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             wr_valid,
  input  logic [DIM*BITS_AB-1:0]           wr_data,
  output logic                             wr_ready,
  input  logic                             start,
  input  logic                             abort,
  output logic                             b_en,
  output logic signed [BITS_AB-1:0]        b_row [DIM],
  output logic                             full,
  output logic                             busy,
  output logic                             done
);

  localparam int AW = $clog2(DIM);
  localparam int CW = AW + 1;
  // sequence counter must reach 2*DIM-1 for the flush phase
  localparam int SW = $clog2(2 * DIM);

  typedef enum logic [1:0] {FILL, FULL, STREAM, FLUSH} state_t;

  state_t                     state;
  logic [CW-1:0]              wr_cnt;
  logic [SW-1:0]              seq_cnt;
  logic signed [BITS_AB-1:0]  mem [DIM][DIM];

  // status flags decode directly from the state register
  assign wr_ready = (state == FILL);
  assign full     = (state == FULL);
  assign busy     = (state == STREAM) || (state == FLUSH);

  // tile fill, stream and flush sequencing with registered skew-buffer outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= FILL;
      wr_cnt  <= '0;
      seq_cnt <= '0;
      b_en    <= 1'b0;
      done    <= 1'b0;
      for (int r = 0; r < DIM; r++) begin
        b_row[r] <= '0;
        for (int k = 0; k < DIM; k++) begin
          mem[r][k] <= '0;
        end
      end
    end else begin
      done <= 1'b0;
      if (abort) begin
        // abort wins over start and writes; buffered rows are left for the next fill to overwrite
        state   <= FILL;
        wr_cnt  <= '0;
        seq_cnt <= '0;
        b_en    <= 1'b0;
        for (int k = 0; k < DIM; k++) begin
          b_row[k] <= '0;
        end
      end else begin
        case (state)
          FILL: begin
            if (wr_valid) begin
              for (int k = 0; k < DIM; k++) begin
                mem[wr_cnt[AW-1:0]][k] <= wr_data[k*BITS_AB +: BITS_AB];
              end
              wr_cnt <= wr_cnt + CW'(1);
              if (wr_cnt == CW'(DIM - 1)) begin
                state <= FULL;
              end
            end
          end
          FULL: begin
            if (start) begin
              // row 0 appears in the cycle right after start is sampled
              state   <= STREAM;
              b_en    <= 1'b1;
              seq_cnt <= SW'(1);
              for (int k = 0; k < DIM; k++) begin
                b_row[k] <= mem[0][k];
              end
            end
          end
          STREAM: begin
            // seq_cnt is the index of the next row to present
            if (seq_cnt == SW'(DIM)) begin
              state   <= FLUSH;
              seq_cnt <= SW'(1);
              for (int k = 0; k < DIM; k++) begin
                b_row[k] <= '0;
              end
            end else begin
              seq_cnt <= seq_cnt + SW'(1);
              for (int k = 0; k < DIM; k++) begin
                b_row[k] <= mem[seq_cnt[AW-1:0]][k];
              end
            end
          end
          FLUSH: begin
            // zero rows push the last data through the deepest skew lane
            if (seq_cnt == SW'(2 * DIM - 1)) begin
              state   <= FILL;
              b_en    <= 1'b0;
              done    <= 1'b1;
              wr_cnt  <= '0;
              seq_cnt <= '0;
            end else begin
              seq_cnt <= seq_cnt + SW'(1);
            end
          end
          default: begin
            state <= FILL;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_b_tile_loader.sv
// tb/tb_b_tile_loader.sv - self-checking bench for b_tile_loader
module tb_b_tile_loader;
  localparam int DIM  = 8;
  localparam int BITS = 8;
  localparam int W    = DIM * BITS;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic wr_valid = 1'b0;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic [W-1:0] wr_data = '0;
  logic wr_ready, b_en, full, busy, done;
  logic signed [BITS-1:0] b_row [DIM];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  b_tile_loader #(.BITS_AB(BITS), .DIM(DIM)) dut (
    .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid), .wr_data(wr_data),
    .wr_ready(wr_ready), .start(start), .abort(abort), .b_en(b_en),
    .b_row(b_row), .full(full), .busy(busy), .done(done)
  );

  // reference model: tile contents plus a queue of future output cycles
  typedef struct {logic en; logic dn; logic [W-1:0] row;} out_t;
  out_t m_q[$];
  out_t m_cur;
  logic [W-1:0] m_tile [DIM];
  int m_loaded;
  bit m_full;
  logic [BITS-1:0] sk [DIM][DIM];

  typedef struct {
    bit wv; bit st; bit ab; int reps;
    bit e_en; int e_row; bit e_done; bit e_rdy; bit e_full; bit e_busy;
  } vec_t;
  vec_t tbl [11];

  function automatic logic [W-1:0] pack_row();
    logic [W-1:0] v;
    for (int k = 0; k < DIM; k++) v[k*BITS +: BITS] = b_row[k];
    return v;
  endfunction

  function automatic logic [W-1:0] pat(input int r);
    logic [W-1:0] v;
    for (int k = 0; k < DIM; k++) v[k*BITS +: BITS] = BITS'(8 * r + k + 1);
    return v;
  endfunction

  function automatic logic [W-1:0] rnd_row();
    return {$urandom, $urandom};
  endfunction

  function automatic logic [W-1:0] skew_out();
    logic [W-1:0] v;
    for (int k = 0; k < DIM; k++) v[k*BITS +: BITS] = sk[k][k];
    return v;
  endfunction

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_loaded = 0;
    m_full = 0;
    m_cur = '{1'b0, 1'b0, '0};
    for (int r = 0; r < DIM; r++) begin
      m_tile[r] = '0;
      for (int j = 0; j < DIM; j++) sk[r][j] = '0;
    end
  endtask

  // one clock: drive inputs, advance the model, sample #1 after the edge and compare
  task automatic step(input logic wv, input logic [W-1:0] wd, input logic st, input logic ab);
    bit exp_rdy, exp_busy;
    wr_valid = wv; wr_data = wd; start = st; abort = ab;
    if (ab) begin
      m_q.delete();
      m_loaded = 0;
      m_full = 0;
      m_cur = '{1'b0, 1'b0, '0};
    end else if (m_q.size() > 0) begin
      m_cur = m_q.pop_front();
    end else if (m_full) begin
      m_cur = '{1'b0, 1'b0, '0};
      if (st) begin
        for (int r = 0; r < DIM; r++) m_q.push_back('{1'b1, 1'b0, m_tile[r]});
        for (int r = 0; r < 2 * DIM - 1; r++) m_q.push_back('{1'b1, 1'b0, '0});
        m_q.push_back('{1'b0, 1'b1, '0});
        m_full = 0;
        m_loaded = 0;
        m_cur = m_q.pop_front();
      end
    end else begin
      m_cur = '{1'b0, 1'b0, '0};
      if (wv) begin
        m_tile[m_loaded] = wd;
        m_loaded++;
        if (m_loaded == DIM) m_full = 1;
      end
    end
    exp_rdy  = (m_q.size() == 0) && !m_full;
    exp_busy = (m_q.size() > 0);
    @(posedge clk);
    #1;
    if (b_en) begin
      for (int k = 0; k < DIM; k++) begin
        for (int j = k; j > 0; j--) sk[k][j] = sk[k][j-1];
        sk[k][0] = b_row[k];
      end
    end
    chk("model", 80'({b_en, done, wr_ready, full, busy, pack_row()}),
        80'({m_cur.en, m_cur.dn, exp_rdy, m_full, exp_busy, m_cur.row}));
  endtask

  initial begin
    logic [W-1:0] exp_row, neg_row;
    int wcnt, flag;

    model_reset();
    #2;
    chk("reset_state", 80'({b_en, done, wr_ready, full, busy, pack_row()}), 80'({5'b00100, 64'h0}));
    @(posedge clk);
    #3 rst_n = 1'b1;

    // directed fill / ignored inputs / stream, with per-phase expectations
    tbl[0]  = '{0, 1, 0, 1,  0, -1, 0, 1, 0, 0};
    tbl[1]  = '{1, 0, 0, 3,  0, -1, 0, 1, 0, 0};
    tbl[2]  = '{0, 1, 0, 2,  0, -1, 0, 1, 0, 0};
    tbl[3]  = '{1, 0, 0, 4,  0, -1, 0, 1, 0, 0};
    tbl[4]  = '{1, 0, 0, 1,  0, -1, 0, 0, 1, 0};
    tbl[5]  = '{1, 0, 0, 3,  0, -1, 0, 0, 1, 0};
    tbl[6]  = '{0, 1, 0, 1,  1,  0, 0, 0, 0, 1};
    tbl[7]  = '{0, 0, 0, 7,  1,  1, 0, 0, 0, 1};
    tbl[8]  = '{0, 0, 0, 15, 1, -1, 0, 0, 0, 1};
    tbl[9]  = '{0, 0, 0, 1,  0, -1, 1, 1, 0, 0};
    tbl[10] = '{0, 0, 0, 1,  0, -1, 0, 1, 0, 0};
    wcnt = 0;
    for (int i = 0; i < 11; i++) begin
      for (int j = 0; j < tbl[i].reps; j++) begin
        step(tbl[i].wv, pat(wcnt), tbl[i].st, tbl[i].ab);
        if (tbl[i].wv) wcnt++;
        exp_row = (tbl[i].e_row < 0) ? '0 : pat(tbl[i].e_row + j);
        chk($sformatf("tbl%0d.%0d", i, j), 80'({b_en, done, wr_ready, full, busy, pack_row()}),
            80'({tbl[i].e_en, tbl[i].e_done, tbl[i].e_rdy, tbl[i].e_full, tbl[i].e_busy, exp_row}));
      end
    end

    // abort at stream cycle 4, then refill and stream a fresh tile
    for (int r = 0; r < DIM; r++) step(1'b1, pat(20 + r), 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    for (int r = 0; r < 4; r++) step(1'b0, '0, 1'b0, 1'b0);
    chk("abort_pre_row", 80'(pack_row()), 80'(pat(24)));
    step(1'b0, '0, 1'b0, 1'b1);
    chk("abort_outputs", 80'({b_en, done, wr_ready, full, busy}), 80'(5'b00100));
    flag = 0;
    for (int r = 0; r < 30; r++) begin
      step(1'b0, '0, 1'b0, 1'b0);
      if (b_en || done) flag = 1;
    end
    chk("abort_quiet", 80'(flag), 80'(0));
    for (int r = 0; r < DIM; r++) step(1'b1, rnd_row(), 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    for (int r = 0; r < 3 * DIM + 1; r++) step(1'b0, '0, 1'b0, 1'b0);

    // negative values pass bit-exact and the skew buffer drains to zero
    neg_row = 64'h0000_0000_007f_ff80;
    for (int r = 0; r < DIM; r++) step(1'b1, (r == 0) ? neg_row : rnd_row(), 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    chk("neg_e0", {72'b0, b_row[0]}, 80'h80);
    chk("neg_e1", {72'b0, b_row[1]}, 80'hff);
    chk("neg_e2", {72'b0, b_row[2]}, 80'h7f);
    flag = 0;
    for (int r = 0; r < 40 && flag == 0; r++) begin
      step(1'b0, '0, 1'b0, 1'b0);
      if (done) flag = 1;
    end
    chk("neg_done_seen", 80'(flag), 80'(1));
    chk("skew_drained", 80'(skew_out()), 80'(0));

    // asynchronous reset pulse during flush
    for (int r = 0; r < DIM; r++) step(1'b1, rnd_row(), 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    for (int r = 0; r < DIM + 3; r++) step(1'b0, '0, 1'b0, 1'b0);
    chk("pre_reset_busy", 80'({b_en, busy}), 80'(2'b11));
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset", 80'({b_en, done, wr_ready, full, busy, pack_row()}), 80'({5'b00100, 64'h0}));
    model_reset();
    @(posedge clk);
    #3 rst_n = 1'b1;
    for (int r = 0; r < 4; r++) step(1'b0, '0, 1'b0, 1'b0);
    for (int r = 0; r < DIM; r++) step(1'b1, pat(50 + r), 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    chk("post_reset_row0", 80'(pack_row()), 80'(pat(50)));
    for (int r = 0; r < 3 * DIM + 1; r++) step(1'b0, '0, 1'b0, 1'b0);

    // randomized traffic against the model
    for (int i = 0; i < 800; i++) begin
      step(1'($urandom_range(0, 1)), rnd_row(), ($urandom_range(0, 7) == 0),
           ($urandom_range(0, 63) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
